req_grant_sched: RTL and testbench
==================================

# req_grant_sched

Round-robin request/grant scheduler that shares one downstream resource among N requesters and bounds grant latency. When it samples any `req`, it chooses a winner by rotating priority. It then issues a one-cycle grant exactly MIN_LAT to MAX_LAT cycles later, gated by resource readiness. If the window closes without readiness, it flags a timeout instead. The block is the controller whose behaviour the team's `req |-> ##[MIN_LAT:MAX_LAT] grant` assertions check.

## Interface
Parameters:
- `N`, 4, number of requesters (≥2).
- `MIN_LAT`, 3, earliest grant edge after request sample (≥2).
- `MAX_LAT`, 5, latest grant edge after request sample (≥MIN_LAT).
- `CW`, 16, width of statistics counters.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in N: per-requester request; each requester holds it until it sees its `gnt` bit, then drops it.
- `res_ready` in 1: resource can accept an owner this cycle.
- `gnt` out N: one-hot, one-cycle grant pulse.
- `gnt_id` out $clog2(N): index of the current or last winner.
- `busy` out 1: a request is in service (states WAIT or DONE).
- `timeout_err` out 1: one-cycle pulse; the winner was not granted by MAX_LAT.
- `grant_count` out CW: saturating count of grants.
- `timeout_count` out CW: saturating count of timeouts.

## Operation
- State machine has three states: IDLE, WAIT, DONE. Round-robin pointer `ptr` has range 0..N-1.
- **IDLE:**
  - At an edge where `req != 0`, this edge is E0.
  - Winner is the first set bit at or above `ptr`, wrapping modulo N.
  - At E0 the block registers `gnt_id` = winner, sets `cnt` = 1 and moves to WAIT.
- **WAIT**, evaluated at edge E0+j with `cnt` = j, in this priority order:
  1. `req[winner]`=0 means abort. Go to IDLE with no grant and no error; `ptr` is unchanged.
  2. j ≥ MIN_LAT-1 and `res_ready`=1 means grant. Register `gnt[winner]`=1, go to DONE, set `ptr` = winner+1 mod N, increment `grant_count`.
  3. j = MAX_LAT-1 (with `res_ready`=0) means timeout. Register `timeout_err`=1, go to DONE, set `ptr` = winner+1 mod N, increment `timeout_count`.
  4. Otherwise increment `cnt` and stay in WAIT.
- **DONE:**
  - Lasts exactly one cycle; `gnt`/`timeout_err` are high during it. Then return to IDLE.
  - `req` is not sampled in DONE, because the winner's `req` is still high at that edge.
- Rules that apply in every state:
  - `res_ready` is ignored before j = MIN_LAT-1.
  - `req` changes of non-winners during WAIT are ignored.
  - A timed-out requester that still holds `req` competes again from IDLE under normal round-robin.
- Counters saturate at 2^CW-1 and never wrap.
- `cnt` needs $clog2(MAX_LAT+1) bits.

## Timing
- Reset is synchronous. At the first edge with `rst`=1, the block enters state IDLE and clears:
  - `ptr`, `cnt` = 0;
  - `gnt`, `timeout_err`, `busy` = 0;
  - `gnt_id` = 0;
  - `grant_count`, `timeout_count` = 0.
- `rst` takes priority over everything, including in WAIT or DONE mid-service; it produces no grant and no timeout.
- All outputs are registered.
- `gnt[w]` is sampled high at exactly one edge E0+k, where k is the smallest value with MIN_LAT ≤ k ≤ MAX_LAT for which `res_ready` was sampled 1 at E0+k-1.
- Otherwise `timeout_err` is sampled high at E0+MAX_LAT and no `gnt` bit is asserted for that service.
- `gnt` and `timeout_err` are never high together. `gnt` is never high for a bit whose `req` was 0 at E0.
- `busy` is high from the cycle after E0 through DONE.
- Back-to-back service with `res_ready` always 1: the next E0 is the edge after DONE, giving a grant period of MIN_LAT+1 cycles.

## Test plan
All scenarios use defaults: N=4, MIN_LAT=3, MAX_LAT=5.
1. Single request:
   - Stimulus: `req`=0001 from edge E0, `res_ready`=1, requester drops `req` after its grant.
   - Required: `gnt`=0001 only at E0+3, `gnt_id`=0, `busy` high at E0+1..E0+3, `grant_count`=1.
2. Late ready:
   - Stimulus: `req`=0010, `res_ready` first sampled 1 at E0+4.
   - Required: `gnt`=0010 at E0+5, no `timeout_err`.
3. Timeout:
   - Stimulus: `req`=0100, `res_ready`=0 throughout.
   - Required: no `gnt`, `timeout_err` at E0+5, `timeout_count`=1, next winner chosen from `ptr`=3.
4. Round-robin fairness:
   - Stimulus: `req`=1111 held, each requester drops its bit one cycle after its grant, `res_ready`=1.
   - Required: grants to 0,1,2,3 at E0+3, +7, +11, +15.
5. Abort:
   - Stimulus: `req`=0100 dropped before edge E0+2, `res_ready`=1.
   - Required: no `gnt`, no `timeout_err`, IDLE at E0+2, `ptr` unchanged.
6. Reset mid-WAIT:
   - Stimulus: `rst`=1 at E0+2.
   - Required: all outputs 0 and counters 0 from E0+2, and no grant at E0+3.

Source files
------------

// File: rtl/req_grant_sched.sv
// Round-robin request/grant scheduler with a bounded grant window [MIN_LAT, MAX_LAT]
// after the request sample; flags a timeout if the resource never becomes ready.
//
// state | meaning
// IDLE  | waiting for any req; picks winner by rotating priority
// WAIT  | winner chosen, counting toward the grant window
// DONE  | one cycle with gnt or timeout_err high; req not sampled
module req_grant_sched #(
  parameter int N       = 4,
  parameter int MIN_LAT = 3,
  parameter int MAX_LAT = 5,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 res_ready,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CW-1:0]        grant_count,
  output logic [CW-1:0]        timeout_count
);

  localparam int IW   = $clog2(N);
  localparam int CNTW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]   id_d, win, idx, ptr_after;
  logic [N-1:0]    gnt_d;
  logic            to_d, busy_d, found, grant_inc, timeout_inc;

  // First requester at or above ptr, wrapping modulo N.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign ptr_after = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    id_d        = gnt_id;
    gnt_d       = '0;
    to_d        = 1'b0;
    grant_inc   = 1'b0;
    timeout_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = win;
          cnt_d   = CNTW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req[gnt_id]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNTW'(MIN_LAT - 1) && res_ready) begin
          gnt_d[gnt_id] = 1'b1;
          state_d       = DONE;
          ptr_d         = ptr_after;
          grant_inc     = 1'b1;
        end else if (cnt_q == CNTW'(MAX_LAT - 1)) begin
          to_d        = 1'b1;
          state_d     = DONE;
          ptr_d       = ptr_after;
          timeout_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      gnt_id        <= '0;
      gnt           <= '0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
      grant_count   <= '0;
      timeout_count <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_id      <= id_d;
      gnt         <= gnt_d;
      timeout_err <= to_d;
      busy        <= busy_d;
      // Saturate rather than wrap.
      if (grant_inc && grant_count != '1)
        grant_count <= grant_count + CW'(1);
      if (timeout_inc && timeout_count != '1)
        timeout_count <= timeout_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_req_grant_sched.sv
// Directed bench for req_grant_sched; CW is narrowed to 3 so grant_count saturation
// is reached within the sequence.
module tb_req_grant_sched;
  localparam int N       = 4;
  localparam int MIN_LAT = 3;
  localparam int MAX_LAT = 5;
  localparam int CW      = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          res_ready = 1'b0;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic          timeout_err;
  logic [CW-1:0] grant_count;
  logic [CW-1:0] timeout_count;

  int checks = 0;
  int errors = 0;

  req_grant_sched #(.N(N), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .res_ready(res_ready),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout_err(timeout_err),
    .grant_count(grant_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] g, input logic to, input logic b);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(to));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic chk_cnt(input string tag, input int gc, input int tc);
    chk({tag, ".grant_count"}, 32'(grant_count), gc);
    chk({tag, ".timeout_count"}, 32'(timeout_count), tc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk_out("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset.gnt_id", 32'(gnt_id), 0);
    chk_cnt("reset", 0, 0);
    rst = 1'b0;
    tick();

    // Round-robin fairness: all four request, grant period MIN_LAT+1
    req = 4'b1111; res_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      tick(); chk("rr.gnt_id", 32'(gnt_id), r); chk_out("rr.e0", 4'b0000, 1'b0, 1'b1);
      tick(); chk_out("rr.e1", 4'b0000, 1'b0, 1'b1);
      tick(); chk_out("rr.grant", N'(1 << r), 1'b0, 1'b1);
      tick(); chk_out("rr.done", 4'b0000, 1'b0, 1'b0);
      req = req & ~N'(1 << r);
    end
    chk_cnt("rr", 4, 0);

    // Single request, ready throughout: grant at E0+3, not earlier
    req = 4'b0001; res_ready = 1'b1;
    tick(); chk("single.gnt_id", 32'(gnt_id), 0); chk_out("single.e1", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("single.e2", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("single.e3", 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    tick(); chk_out("single.e4", 4'b0000, 1'b0, 1'b0);
    chk_cnt("single", 5, 0);

    // Late ready at the last permitted edge
    req = 4'b0010; res_ready = 1'b0;
    tick(); chk("late.gnt_id", 32'(gnt_id), 1);
    tick(); chk_out("late.e2", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("late.e3", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("late.e4", 4'b0000, 1'b0, 1'b1);
    res_ready = 1'b1;
    tick(); chk_out("late.e5", 4'b0010, 1'b0, 1'b1);
    req = 4'b0000;
    tick(); chk_out("late.e6", 4'b0000, 1'b0, 1'b0);
    chk_cnt("late", 6, 0);

    // Timeout, then ptr must have moved past requester 2
    req = 4'b0100; res_ready = 1'b0;
    tick(); chk("to.gnt_id", 32'(gnt_id), 2);
    for (int k = 2; k <= 4; k++) begin
      tick(); chk_out("to.wait", 4'b0000, 1'b0, 1'b1);
    end
    tick(); chk_out("to.e5", 4'b0000, 1'b1, 1'b1);
    chk_cnt("to", 6, 1);
    req = 4'b0101; res_ready = 1'b1;
    tick(); chk_out("to.done", 4'b0000, 1'b0, 1'b0);
    tick(); chk("to.next_id", 32'(gnt_id), 0); chk_out("to.next_e1", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("to.next_e2", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("to.next_e3", 4'b0001, 1'b0, 1'b1);
    req = 4'b0000;
    tick(); chk_out("to.next_e4", 4'b0000, 1'b0, 1'b0);
    chk_cnt("to.next", 7, 1);

    // Abort: winner drops req before E0+2 while ready is high; ptr stays at 1
    req = 4'b0100; res_ready = 1'b1;
    tick(); chk("abort.gnt_id", 32'(gnt_id), 2); chk_out("abort.e1", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("abort.e2pre", 4'b0000, 1'b0, 1'b1);
    req = 4'b0000;
    tick(); chk_out("abort.idle", 4'b0000, 1'b0, 1'b0);
    tick(); chk_out("abort.e3", 4'b0000, 1'b0, 1'b0);
    chk_cnt("abort", 7, 1);
    req = 4'b0011;
    tick(); chk("abort.ptr_kept", 32'(gnt_id), 1);
    tick(); chk_out("abort.next_e2", 4'b0000, 1'b0, 1'b1);
    tick(); chk_out("abort.next_e3", 4'b0010, 1'b0, 1'b1);
    req = 4'b0000;
    tick(); chk_out("abort.next_e4", 4'b0000, 1'b0, 1'b0);
    chk_cnt("saturate", 7, 1);

    // Reset mid-WAIT
    req = 4'b0010; res_ready = 1'b1;
    tick(); chk("rstw.gnt_id", 32'(gnt_id), 1);
    tick(); chk_out("rstw.e2pre", 4'b0000, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); chk_out("rstw.e2", 4'b0000, 1'b0, 1'b0);
    chk("rstw.gnt_id0", 32'(gnt_id), 0);
    chk_cnt("rstw", 0, 0);
    rst = 1'b0; req = 4'b0000;
    tick(); chk_out("rstw.e3", 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
